fetch_queue: RTL
================

# fetch_queue

Prefetching instruction-fetch stage that sits directly upstream of the single-cycle execute stage and replaces its combinational instruction-memory lookup. It issues word-addressed fetches to an external instruction memory over a request/grant interface with in-order responses. It buffers returned instructions with their PCs in a small FIFO and presents them to the execute stage through a valid/ready handshake. A redirect (taken branch, jump, `jr`) flushes the queue and discards in-flight responses.

## Interface
- `DEPTH`, 4: queue entries and maximum outstanding fetches; power of two, ≥2.
- `RESET_PC`, 32'h0: word address fetched first after reset.
- `clk`  in  1  clock; all state updates on posedge.
- `rstd`  in  1  synchronous, active-high reset.
- `mem_req`  out  1  fetch request; a fetch is accepted in a cycle with `mem_req && mem_gnt`.
- `mem_addr`  out  32  word address of the request; equals internal `fetch_pc`.
- `mem_gnt`  in  1  memory accepts the request this cycle.
- `mem_rvalid`  in  1  response valid; responses arrive in request order, no earlier than the cycle after grant.
- `mem_rdata`  in  32  instruction word.
- `redirect`  in  1  single-cycle pulse; next fetch comes from `redirect_pc`.
- `redirect_pc`  in  32  redirect target word address.
- `ins_valid`  out  1  head entry available.
- `ins`  out  32  head instruction; 0 when empty.
- `ins_pc`  out  32  PC of head instruction; 0 when empty.
- `ins_ready`  in  1  consumer takes the head this cycle.

## Operation
- State: `fetch_pc` (32), `resp_pc` (32, PC of the next expected response), `outstanding` and `drop_cnt` (each $clog2(DEPTH+1) bits), FIFO of {pc, ins}, 64 bits per entry.
- Issue: `mem_req = !rstd && (count + outstanding < DEPTH)`. This credit rule guarantees that every response has a FIFO slot. On grant, `fetch_pc` increments by 1 (mod 2^32) and `outstanding` increments.
- Response: on `mem_rvalid`, `outstanding` decrements.
  - If `drop_cnt != 0`: discard the response and decrement `drop_cnt`.
  - Otherwise: push {`resp_pc`, `mem_rdata`} and increment `resp_pc` by 1 (mod 2^32).
- Pop: on `ins_valid && ins_ready`, the head is removed. Simultaneous push and pop on a non-empty queue keeps `count` unchanged.
- Redirect cycle, applied after all other updates of that cycle:
  - A pop handshake in that cycle completes normally.
  - The FIFO is then cleared.
  - `fetch_pc` and `resp_pc` load `redirect_pc`.
  - `drop_cnt` loads the post-cycle `outstanding`. This count includes a grant made in the redirect cycle. A response arriving in the redirect cycle is discarded.
- Redirect while `drop_cnt != 0`: `drop_cnt` reloads with the new `outstanding`, so older stale responses remain covered.
- `rvalid` with `outstanding == 0` is a protocol violation. It is covered by a bench assertion, and RTL behaviour is undefined.

## Timing
- Reset, while `rstd` is high and in the first cycle after it falls:
  - `mem_req`=0 during reset.
  - `mem_addr`=`RESET_PC`.
  - `ins_valid`=0, `ins`=0, `ins_pc`=0.
  - Counters=0.
- Reset mid-operation drops all in-flight state without draining. The memory is reset together with this block.
- Latency: a response in cycle N is visible on `ins` in cycle N+1; there is no bypass.
  - With 1-cycle memory and constant `mem_gnt`, the request in cycle 0 after reset release gives `ins_valid` in cycle 2.
- Throughput: 1 instruction/cycle sustained when memory latency ≤ DEPTH−1 and the consumer is always ready.
- Full: `count==DEPTH` deasserts `mem_req` and never drops data.
- Empty: `ins_valid`=0 and `ins_ready` is ignored.
- `ins`/`ins_pc` are stable while `ins_valid && !ins_ready`, except when a redirect occurs.

## Structure
- Shared package `cpu_pkg`: `WORD_W=32`, `word_t`, and a `fetch_entry_t` struct {pc, ins}, reused by execute.
- One sub-module, `sync_fifo` (params DEPTH, WIDTH; ports push/pop/flush/full/empty/count, with show-ahead head output).
- Credit, drop, and PC logic stay in `fetch_queue`.

## Test plan
- **Reset then stream:** 1-cycle memory returning `mem_rdata=addr+32'h100`, consumer always ready → `ins_pc` = 0,1,2,… from cycle 2 with `ins`=32'h100,32'h101,…, one per cycle.
- **Backpressure:** `ins_ready`=0 for 10 cycles → `mem_req` drops after 4 accepted fetches. The head stays at pc 0 and no entry is lost. On release, pcs 0..3 drain and then streaming continues.
- **Redirect with in-flight:** 3-cycle memory, `redirect_pc`=32'h40 while 2 requests are outstanding → the 2 stale responses are discarded. The next `ins_pc` is 32'h40, then 32'h41.
- **Redirect same cycle as grant and rvalid** → both are treated as stale. A pop in that cycle completes and no old-path instruction follows.
- **Wrap:** `redirect_pc`=32'hFFFFFFFF → `ins_pc` 32'hFFFFFFFF then 32'h0.
- **Mid-stream reset:** `rstd` pulsed with 3 queued and 2 outstanding → `ins_valid`=0 the next cycle and fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch queue and the execute stage.
//   WORD_W        : machine word width
//   word_t        : one machine word (instruction or word address)
//   fetch_entry_t : one fetched instruction tagged with its PC
//   word_inc      : modulo-2^WORD_W increment of a word address
package cpu_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t ins;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

  function automatic word_t word_inc(input word_t w);
    return w + word_t'(1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small single-clock FIFO with show-ahead head output.
// Ports:
//   clk          : clock
//   srst_i       : synchronous active-high reset (empties the FIFO)
//   push_i       : write push_data_i this cycle (ignored when full without a pop)
//   push_data_i  : data to write
//   pop_i        : remove the head this cycle (ignored when empty)
//   flush_i      : empty the FIFO after this cycle's push/pop
//   full_o       : count_o == DEPTH
//   empty_o      : count_o == 0
//   count_o      : number of stored entries
//   head_o       : oldest entry, valid whenever !empty_o
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         srst_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_data_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [WIDTH-1:0]             head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic do_push;
  logic do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Show-ahead: the head is read straight out of the storage array so the
  // consumer sees it in the same cycle it becomes the oldest entry.
  assign head_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is allowed when the same cycle frees a slot.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so the pointers wrap naturally.
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Flush wins over everything that happened this cycle.
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only observed after it was written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Prefetching instruction-fetch stage in front of the execute stage.
// Issues word-addressed fetches over a request/grant memory interface with
// in-order responses, buffers {pc, ins} pairs and hands them to execute over
// a valid/ready handshake. A redirect flushes the queue and marks every
// fetch still in flight as stale so its response is discarded.
// Ports:
//   clk          : clock
//   rstd         : synchronous active-high reset
//   mem_req      : fetch request (accepted when mem_req && mem_gnt)
//   mem_addr     : word address of the request
//   mem_gnt      : memory accepts the request this cycle
//   mem_rvalid   : response valid (in request order)
//   mem_rdata    : response instruction word
//   redirect     : single-cycle pulse, restart fetch at redirect_pc
//   redirect_pc  : redirect target word address
//   ins_valid    : head instruction available
//   ins          : head instruction (0 when empty)
//   ins_pc       : PC of the head instruction (0 when empty)
//   ins_ready    : consumer takes the head this cycle
module fetch_queue import cpu_pkg::*; #(
  parameter int    DEPTH    = 4,
  parameter word_t RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rstd,
  output logic              mem_req,
  output logic [WORD_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              ins_valid,
  output logic [WORD_W-1:0] ins,
  output logic [WORD_W-1:0] ins_pc,
  input  logic              ins_ready
);

  localparam int CW = $clog2(DEPTH+1);

  word_t         fetch_pc_q,    fetch_pc_d;
  word_t         resp_pc_q,     resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q,    drop_cnt_d;

  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_head;
  fetch_entry_t  push_entry;
  logic          fifo_push;
  logic          fifo_pop;

  logic          grant;
  logic          resp_stale;
  logic [CW:0]   credit_used;

  // ---------------------------------------------------------------------
  // Issue: a slot is reserved for every fetch in flight, so a response can
  // always be pushed without a full check.
  // ---------------------------------------------------------------------
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding_q};
  // The full term is implied by the credit rule; it keeps the request low
  // even if the two counters were ever inconsistent.
  assign mem_req  = !rstd && !fifo_full && (credit_used < (CW+1)'(DEPTH));
  assign mem_addr = rstd ? RESET_PC : fetch_pc_q;
  assign grant    = mem_req && mem_gnt;

  // ---------------------------------------------------------------------
  // Response: responses belonging to fetches issued before the last
  // redirect are counted off by drop_cnt and never enter the queue.
  // ---------------------------------------------------------------------
  assign resp_stale = (drop_cnt_q != '0);
  assign fifo_push  = mem_rvalid && !resp_stale;
  assign push_entry = '{pc: resp_pc_q, ins: mem_rdata};

  // ---------------------------------------------------------------------
  // Consumer side
  // ---------------------------------------------------------------------
  assign ins_valid = !rstd && !fifo_empty;
  assign fifo_pop  = ins_valid && ins_ready;
  assign ins       = ins_valid ? fifo_head.ins : '0;
  assign ins_pc    = ins_valid ? fifo_head.pc  : '0;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FETCH_ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .srst_i      (rstd),
    .push_i      (fifo_push),
    .push_data_i (push_entry),
    .pop_i       (fifo_pop),
    .flush_i     (redirect),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count),
    .head_o      (fifo_head)
  );

  // ---------------------------------------------------------------------
  // Next state for PCs and counters
  // ---------------------------------------------------------------------
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CW'(grant) - CW'(mem_rvalid);

    if (grant) begin
      fetch_pc_d = word_inc(fetch_pc_q);
    end

    if (mem_rvalid) begin
      if (resp_stale) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end else begin
        resp_pc_d = word_inc(resp_pc_q);
      end
    end

    // Redirect is applied last: everything still in flight after this
    // cycle (including a grant made now) is stale. Reloading rather than
    // adding keeps older stale fetches covered because they are still
    // part of outstanding.
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      drop_cnt_d = outstanding_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rstd) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

endmodule
